// File: rtl/pulse_width_monitor_if.sv
// Bus between the pulse source / result consumer and the pulse width monitor.
// The master drives the pulse and clear; the slave (the monitor) drives results.
interface pulse_width_monitor_if #(
    parameter int CountBits = 8
);
    logic                 pulse_in;
    logic                 clr;
    logic                 valid;
    logic [CountBits-1:0] width;
    logic                 too_short;
    logic                 too_long;
    logic                 err;
    logic [CountBits-1:0] good_count;
    logic                 busy;

    modport master (
        output pulse_in, clr,
        input  valid, width, too_short, too_long, err, good_count, busy
    );

    modport slave (
        input  pulse_in, clr,
        output valid, width, too_short, too_long, err, good_count, busy
    );
endinterface

// File: rtl/pulse_width_monitor.sv
// Synchronises an asynchronous active-high pulse, measures its width in clock
// cycles, classifies it as legal / too short / too long and counts good pulses.
module pulse_width_monitor #(
    parameter int SyncStages = 2,
    parameter int MinWidth   = 2,
    parameter int MaxWidth   = 8,
    parameter int CountBits  = 8
) (
    input  logic                  clk,
    input  logic                  _reset,
    pulse_width_monitor_if.slave  bus
);

    typedef enum logic [1:0] {ARM, IDLE, HIGH} state_t;

    state_t               state_q, state_d;
    logic [CountBits-1:0] cnt_q, cnt_d;
    logic [SyncStages-1:0] sync_q;
    logic                 s;

    logic                 ev_valid, ev_short, ev_long;
    logic [CountBits-1:0] ev_width;

    logic                 valid_q, short_q, long_q, err_q;
    logic [CountBits-1:0] width_q, good_q;

    // Synchroniser resets high so a pulse already present at release is
    // treated as stuck and skipped by ARM.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) sync_q <= '1;
        // NOTE: non-blocking assignment lets every flop sample the pre-edge value, forming a true shift chain.
        else         sync_q <= {sync_q[SyncStages-2:0], bus.pulse_in};
    end

    assign s = sync_q[SyncStages-1];

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q <= ARM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        ev_valid = 1'b0;
        ev_short = 1'b0;
        ev_long  = 1'b0;
        ev_width = cnt_q;
        case (state_q)
            ARM: begin
                if (!s) state_d = IDLE;
            end
            IDLE: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = CountBits'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    ev_valid = 1'b1;
                    ev_short = (cnt_q < CountBits'(MinWidth));
                    state_d  = IDLE;
                end else if (cnt_q < CountBits'(MaxWidth)) begin
                    cnt_d = cnt_q + CountBits'(1);
                end else begin
                    ev_valid = 1'b1;
                    ev_long  = 1'b1;
                    ev_width = CountBits'(MaxWidth);
                    state_d  = ARM;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            valid_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            width_q <= '0;
        end else begin
            valid_q <= ev_valid;
            short_q <= ev_short;
            long_q  <= ev_long;
            if (ev_valid) width_q <= ev_width;
        end
    end

    // Statistics follow the registered report; clear takes effect before the
    // same-cycle report is accounted.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            err_q  <= 1'b0;
            good_q <= '0;
        end else begin
            err_q <= (err_q & ~bus.clr) | (valid_q & (short_q | long_q));
            if (valid_q && !short_q && !long_q)
                good_q <= (bus.clr ? '0 : good_q) + CountBits'(1);
            else if (bus.clr)
                good_q <= '0;
        end
    end

    assign bus.valid      = valid_q;
    assign bus.too_short  = short_q;
    assign bus.too_long   = long_q;
    assign bus.width      = width_q;
    assign bus.err        = err_q;
    assign bus.good_count = good_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Directed bench for pulse_width_monitor: the stimulus queues expected reports,
// an independent monitor pops and compares each valid the DUT presents.
module tb_pulse_width_monitor;

    localparam int SyncStages = 2;
    localparam int MinWidth   = 2;
    localparam int MaxWidth   = 8;
    localparam int CountBits  = 8;

    typedef struct {
        int cyc;
        int width;
        int ts;
        int tl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];

    pulse_width_monitor_if #(.CountBits(CountBits)) bus();

    pulse_width_monitor #(
        .SyncStages(SyncStages),
        .MinWidth  (MinWidth),
        .MaxWidth  (MaxWidth),
        .CountBits (CountBits)
    ) dut (
        .clk   (clk),
        ._reset(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a w-edge pulse then gap low edges; a report is expected at edge
    // k + SyncStages + 1 + min(w, MaxWidth), k being the edge before the rise.
    task automatic pulse(input int w, input int gap);
        exp_t e;
        int   k;
        bus.pulse_in = 1'b1;
        k = cyc;
        e.cyc   = k + SyncStages + 1 + ((w > MaxWidth) ? MaxWidth : w);
        e.width = (w > MaxWidth) ? MaxWidth : w;
        e.ts    = (w < MinWidth) ? 1 : 0;
        e.tl    = (w > MaxWidth) ? 1 : 0;
        exp_q.push_back(e);
        repeat (w) step();
        bus.pulse_in = 1'b0;
        repeat (gap) step();
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1 width=%0d, expected no valid (cycle %0d)",
                         bus.width, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("width", 32'(bus.width), e.width);
                check("too_short", 32'(bus.too_short), e.ts);
                check("too_long", 32'(bus.too_long), e.tl);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.pulse_in = 1'b0;
        bus.clr = 1'b0;

        // Reset with the input toggling
        repeat (6) begin
            step();
            bus.pulse_in = ~bus.pulse_in;
        end
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_good_count", 32'(bus.good_count), 0);
        check("rst_busy", 32'(bus.busy), 1);
        bus.pulse_in = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("idle_after_release", 32'(bus.busy), 0);

        // Legal 4-cycle pulse
        pulse(4, 6);
        check("good_after_w4", 32'(bus.good_count), 1);
        check("err_after_w4", 32'(bus.err), 0);
        check("width_held", 32'(bus.width), 4);

        // Too-short 1-cycle pulse
        pulse(1, 6);
        check("err_after_w1", 32'(bus.err), 1);
        check("good_after_w1", 32'(bus.good_count), 1);

        // Plain clear
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        check("err_after_clr", 32'(bus.err), 0);
        check("good_after_clr", 32'(bus.good_count), 0);

        // Stuck high for 20 cycles: exactly one too-long report
        pulse(20, 6);
        check("err_after_stuck", 32'(bus.err), 1);
        check("good_after_stuck", 32'(bus.good_count), 0);

        // Width of exactly MaxWidth is legal
        pulse(8, 6);
        check("good_after_w8", 32'(bus.good_count), 1);
        check("width_w8", 32'(bus.width), 8);

        // Back-to-back pulses with one low cycle
        pulse(3, 1);
        pulse(3, 6);
        check("good_after_b2b", 32'(bus.good_count), 3);

        // Clear in the same cycle as a too-short report
        pulse(1, 0);
        repeat (3) step();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        step();
        check("err_clr_same_cycle", 32'(bus.err), 1);
        check("good_clr_same_cycle", 32'(bus.good_count), 0);

        // Reset mid-pulse with the input still high after release
        bus.pulse_in = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (6) step();
        bus.pulse_in = 1'b0;
        repeat (5) step();
        check("err_after_midreset", 32'(bus.err), 0);
        check("good_after_midreset", 32'(bus.good_count), 0);
        pulse(3, 6);
        check("good_after_recover", 32'(bus.good_count), 1);

        check("expected_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
